// File: rtl/ahb_pkg.sv
// Shared AHB encodings, the fixed-burst length helper and the arbiter state type.
// Imported by the arbiter, its round-robin picker and the testbench.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef enum logic [2:0] {
        ST_PARK      = 3'd0,
        ST_OWN       = 3'd1,
        ST_BURST     = 3'd2,
        ST_LOCK      = 3'd3,
        ST_LOCK_TAIL = 3'd4
    } arb_state_t;

    // Undefined-length INCR counts as a single beat: it never freezes the grant.
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            HBURST_SINGLE, HBURST_INCR:   burst_len = 5'd1;
            HBURST_WRAP4, HBURST_INCR4:   burst_len = 5'd4;
            HBURST_WRAP8, HBURST_INCR8:   burst_len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
            default:                      burst_len = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after start,
// wrapping around; returns a one-hot winner and a valid flag.
module ahb_rr_pick
    import ahb_pkg::*;
#(
    parameter int N  = 2,
    parameter int MW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] start,
    output logic [N-1:0]  winner,
    output logic          valid
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] hi_mask;
    logic [N-1:0] hi_req;
    logic [N-1:0] pool;

    // Requests at or above start win first; otherwise the search wraps to index 0.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (i >= int'(start));
        end
        hi_req = req & hi_mask;
        pool   = (hi_req != '0) ? hi_req : req;
        winner = pool & (~pool + ONE);
        valid  = |req;
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with fixed-burst and HMASTLOCK protection,
// parking on DEFAULT_MASTER, and address/data-phase owner tracking for the muxes.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic [MW-1:0]          HMASTER_D,
    output logic                   HMASTLOCK,
    output logic [2:0]             dbg_state,
    output logic [3:0]             dbg_rem
);

    localparam logic [NUM_MASTERS-1:0] DEF_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);

    arb_state_t             state;
    arb_state_t             state_next;
    logic [MW-1:0]          grant_idx;
    logic [MW-1:0]          grant_idx_next;
    logic [NUM_MASTERS-1:0] grant_next;
    logic [MW-1:0]          rr_ptr;
    logic [MW-1:0]          rr_ptr_next;
    logic [MW-1:0]          rr_start;
    logic [NUM_MASTERS-1:0] pick_oh;
    logic [MW-1:0]          pick_idx;
    logic                   pick_valid;
    logic                   lock_gi;
    logic                   can_move;
    logic [3:0]             rem;
    logic [3:0]             rem_next;
    logic [4:0]             len;

    assign lock_gi   = |(HLOCK & HGRANT);
    assign len       = burst_len(HBURST);
    assign dbg_state = state;
    assign dbg_rem   = rem;

    // Remaining fixed-burst address beats of the current address-phase owner.
    always_comb begin
        rem_next = rem;
        case (HTRANS)
            HTRANS_NONSEQ: rem_next = 4'(len - 5'd1);
            HTRANS_SEQ:    rem_next = (rem != 4'd0) ? rem - 4'd1 : rem;
            HTRANS_BUSY:   rem_next = rem;
            default:       rem_next = 4'd0;
        endcase
    end

    assign can_move = (rem_next == 4'd0) && (HTRANS != HTRANS_BUSY);

    assign rr_start = (rr_ptr == MW'(NUM_MASTERS - 1)) ? '0 : rr_ptr + 1'b1;

    ahb_rr_pick #(
        .N  (NUM_MASTERS),
        .MW (MW)
    ) u_pick (
        .req    (HBUSREQ),
        .start  (rr_start),
        .winner (pick_oh),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick_oh[i]) pick_idx = MW'(i);
        end
    end

    // Next-state and grant decision; only takes effect on accepted edges.
    always_comb begin
        state_next     = state;
        grant_next     = HGRANT;
        grant_idx_next = grant_idx;
        rr_ptr_next    = rr_ptr;
        case (state)
            ST_LOCK: begin
                if (!lock_gi) state_next = ST_LOCK_TAIL;
            end
            ST_LOCK_TAIL: begin
                state_next = ST_OWN;
            end
            default: begin
                if (lock_gi) begin
                    state_next = ST_LOCK;
                end else if (!can_move) begin
                    if (rem_next != 4'd0)     state_next = ST_BURST;
                    else if (state == ST_BURST) state_next = ST_OWN;
                end else if (pick_valid) begin
                    grant_next     = pick_oh;
                    grant_idx_next = pick_idx;
                    if (pick_idx != grant_idx) rr_ptr_next = pick_idx;
                    state_next     = ST_OWN;
                end else begin
                    // Parking is not an arbitration win, so the RR pointer keeps its history.
                    grant_next     = DEF_OH;
                    grant_idx_next = DEF_IDX;
                    state_next     = ST_PARK;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_PARK;
            HGRANT    <= DEF_OH;
            grant_idx <= DEF_IDX;
            rr_ptr    <= DEF_IDX;
            HMASTER   <= DEF_IDX;
            HMASTER_D <= DEF_IDX;
            HMASTLOCK <= 1'b0;
            rem       <= 4'd0;
        end else if (HREADY) begin
            state     <= state_next;
            HGRANT    <= grant_next;
            grant_idx <= grant_idx_next;
            rr_ptr    <= rr_ptr_next;
            HMASTER_D <= HMASTER;
            HMASTER   <= grant_idx;
            HMASTLOCK <= lock_gi;
            rem       <= rem_next;
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed testbench for ahb_arbiter with hand-computed expectations:
// reset, fixed burst handover, round-robin, lock, wait states, early termination.
module tb_ahb_arbiter;
    import ahb_pkg::*;

    logic       HCLK;
    logic       HRESETn;
    logic [1:0] HBUSREQ;
    logic [1:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [1:0] HGRANT;
    logic [0:0] HMASTER;
    logic [0:0] HMASTER_D;
    logic       HMASTLOCK;
    logic [2:0] dbg_state;
    logic [3:0] dbg_rem;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] exp_q[$];

    ahb_arbiter #(
        .NUM_MASTERS    (2),
        .DEFAULT_MASTER (0)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTER_D (HMASTER_D),
        .HMASTLOCK (HMASTLOCK),
        .dbg_state (dbg_state),
        .dbg_rem   (dbg_rem)
    );

    // Clock / reset
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        HBUSREQ = 2'b00;
        HLOCK   = 2'b00;
        HTRANS  = HTRANS_IDLE;
        HBURST  = HBURST_SINGLE;
        HREADY  = 1'b1;
    endtask

    // One clock edge; outputs are then sampled 1 ns after it.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic apply_reset();
        HRESETn = 1'b0;
        set_idle();
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        step();
    endtask

    initial begin
        logic [1:0] prev;
        HRESETn = 1'b0;
        set_idle();

        // Reset values, during and after reset
        #12;
        check("rst_in_grant", 32'(HGRANT), 32'h1);
        check("rst_in_hmaster", 32'(HMASTER), 32'h0);
        apply_reset();
        check("rst_grant", 32'(HGRANT), 32'h1);
        check("rst_hmaster", 32'(HMASTER), 32'h0);
        check("rst_hmaster_d", 32'(HMASTER_D), 32'h0);
        check("rst_lock", 32'(HMASTLOCK), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_PARK));
        check("rst_rem", 32'(dbg_rem), 32'h0);

        // INCR4 by M1, M0 requests at beat 2, grant moves as 0x0C is accepted
        apply_reset();
        HBUSREQ = 2'b10;
        step();
        check("a_grant_e1", 32'(HGRANT), 32'h2);
        check("a_hmaster_e1", 32'(HMASTER), 32'h0);
        step();
        check("a_hmaster_e2", 32'(HMASTER), 32'h1);
        check("a_hmaster_d_e2", 32'(HMASTER_D), 32'h0);
        HTRANS = HTRANS_NONSEQ;
        HBURST = HBURST_INCR4;
        step();
        check("a_rem_00", 32'(dbg_rem), 32'h3);
        check("a_state_00", 32'(dbg_state), 32'(ST_BURST));
        check("a_hmaster_d_e3", 32'(HMASTER_D), 32'h1);
        HTRANS  = HTRANS_SEQ;
        HBUSREQ = 2'b11;
        step();
        check("a_rem_04", 32'(dbg_rem), 32'h2);
        check("a_grant_04", 32'(HGRANT), 32'h2);
        step();
        check("a_rem_08", 32'(dbg_rem), 32'h1);
        check("a_grant_08", 32'(HGRANT), 32'h2);
        step();
        check("a_rem_0c", 32'(dbg_rem), 32'h0);
        check("a_grant_0c", 32'(HGRANT), 32'h1);
        check("a_hmaster_0c", 32'(HMASTER), 32'h1);
        check("a_state_0c", 32'(dbg_state), 32'(ST_OWN));
        HTRANS  = HTRANS_IDLE;
        HBUSREQ = 2'b01;
        step();
        check("a_hmaster_hand", 32'(HMASTER), 32'h0);
        check("a_hmaster_d_hand", 32'(HMASTER_D), 32'h1);
        HBUSREQ = 2'b00;
        step();
        check("a_hmaster_d_lag", 32'(HMASTER_D), 32'h0);
        check("a_park_state", 32'(dbg_state), 32'(ST_PARK));
        check("a_park_grant", 32'(HGRANT), 32'h1);

        // Both masters request SINGLE transfers: grants alternate
        apply_reset();
        HBUSREQ = 2'b11;
        HTRANS  = HTRANS_NONSEQ;
        HBURST  = HBURST_SINGLE;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back((i % 2 == 0) ? 2'b10 : 2'b01);
        end
        prev = 2'b01;
        for (int i = 0; i < 8; i++) begin
            logic [1:0] e;
            step();
            e = exp_q.pop_front();
            check("b_rr_grant", 32'(HGRANT), 32'(e));
            check("b_rr_hmaster", 32'(HMASTER), (prev == 2'b10) ? 32'h1 : 32'h0);
            prev = e;
        end
        HBUSREQ = 2'b00;
        HTRANS  = HTRANS_IDLE;
        step();
        check("b_park_state", 32'(dbg_state), 32'(ST_PARK));
        check("b_park_grant", 32'(HGRANT), 32'h1);

        // Locked SINGLE write by M0 to 0x20 while M1 requests
        apply_reset();
        HBUSREQ = 2'b11;
        HLOCK   = 2'b01;
        step();
        check("c_state_lock", 32'(dbg_state), 32'(ST_LOCK));
        check("c_grant_e1", 32'(HGRANT), 32'h1);
        check("c_mastlock_e1", 32'(HMASTLOCK), 32'h1);
        HTRANS = HTRANS_NONSEQ;
        HBURST = HBURST_SINGLE;
        step();
        check("c_grant_e2", 32'(HGRANT), 32'h1);
        check("c_mastlock_e2", 32'(HMASTLOCK), 32'h1);
        HLOCK   = 2'b00;
        HTRANS  = HTRANS_IDLE;
        HBUSREQ = 2'b10;
        step();
        check("c_state_tail", 32'(dbg_state), 32'(ST_LOCK_TAIL));
        check("c_grant_e3", 32'(HGRANT), 32'h1);
        check("c_mastlock_e3", 32'(HMASTLOCK), 32'h0);
        step();
        check("c_grant_e4", 32'(HGRANT), 32'h1);
        check("c_state_e4", 32'(dbg_state), 32'(ST_OWN));
        step();
        check("c_grant_e5", 32'(HGRANT), 32'h2);
        HBUSREQ = 2'b00;
        step();
        check("c_park_grant", 32'(HGRANT), 32'h1);
        check("c_park_state", 32'(dbg_state), 32'(ST_PARK));

        // WRAP4 with three wait states after the first beat
        apply_reset();
        HBUSREQ = 2'b10;
        step();
        step();
        HTRANS = HTRANS_NONSEQ;
        HBURST = HBURST_WRAP4;
        step();
        check("d_rem_08", 32'(dbg_rem), 32'h3);
        HTRANS  = HTRANS_SEQ;
        HBUSREQ = 2'b11;
        HREADY  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("d_wait_rem", 32'(dbg_rem), 32'h3);
            check("d_wait_grant", 32'(HGRANT), 32'h2);
            check("d_wait_hmaster", 32'(HMASTER), 32'h1);
        end
        HREADY = 1'b1;
        step();
        check("d_rem_0c", 32'(dbg_rem), 32'h2);
        check("d_grant_0c", 32'(HGRANT), 32'h2);
        step();
        check("d_rem_00", 32'(dbg_rem), 32'h1);
        check("d_grant_00", 32'(HGRANT), 32'h2);
        step();
        check("d_rem_04", 32'(dbg_rem), 32'h0);
        check("d_grant_04", 32'(HGRANT), 32'h1);
        HTRANS = HTRANS_IDLE;

        // INCR4 terminated by IDLE after two beats
        apply_reset();
        HBUSREQ = 2'b10;
        step();
        step();
        HTRANS = HTRANS_NONSEQ;
        HBURST = HBURST_INCR4;
        step();
        HTRANS  = HTRANS_SEQ;
        HBUSREQ = 2'b11;
        step();
        check("e_rem_beat2", 32'(dbg_rem), 32'h2);
        check("e_grant_beat2", 32'(HGRANT), 32'h2);
        HTRANS = HTRANS_IDLE;
        step();
        check("e_rem_idle", 32'(dbg_rem), 32'h0);
        check("e_grant_idle", 32'(HGRANT), 32'h1);
        check("e_state_idle", 32'(dbg_state), 32'(ST_OWN));

        // Asynchronous reset in the middle of an INCR8
        apply_reset();
        HBUSREQ = 2'b10;
        step();
        step();
        HTRANS = HTRANS_NONSEQ;
        HBURST = HBURST_INCR8;
        step();
        check("f_rem_nonseq", 32'(dbg_rem), 32'h7);
        HTRANS = HTRANS_SEQ;
        step();
        check("f_rem_seq", 32'(dbg_rem), 32'h6);
        #2;
        HRESETn = 1'b0;
        #1;
        check("f_rst_grant", 32'(HGRANT), 32'h1);
        check("f_rst_hmaster", 32'(HMASTER), 32'h0);
        check("f_rst_hmaster_d", 32'(HMASTER_D), 32'h0);
        check("f_rst_rem", 32'(dbg_rem), 32'h0);
        check("f_rst_state", 32'(dbg_state), 32'(ST_PARK));
        check("f_rst_lock", 32'(HMASTLOCK), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
